// File: rtl/clk_period_monitor_pkg.sv
// Shared types for the clock period monitor: FSM state encoding and the
// status flag bundle.
package clk_period_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    typedef struct packed {
        logic error;     // sticky: a period check failed
        logic timeout;   // sticky: counter saturated waiting for an edge
        logic mismatch;  // one-cycle: accompanies valid on a failed check
    } status_t;

endpackage

// File: rtl/sync.sv
// Multi-flop synchronizer for a single-bit asynchronous input.
// Reset value of every stage is ResetValue.
module sync #(
    parameter int unsigned STAGES     = 2,
    parameter bit          ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q, reg_d;

    // shift the input in at the LSB; the MSB is the synchronized value
    always_comb begin
        reg_d = (reg_q << 1) | STAGES'(serial_i);
    end

    // synchronizer flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) reg_q <= {STAGES{ResetValue}};
        else         reg_q <= reg_d;
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of an asynchronous clock in reference-clock cycles,
// checks it against an expected value with tolerance and flags timeouts.
// Optional min/max tracking is built when CLK_PERIOD_MONITOR_MINMAX_EN
// is defined; otherwise min_o/max_o are constants.
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic                clk_meas_i,
    input  logic [CntWidth-1:0] exp_period_i,
    input  logic [CntWidth-1:0] tol_i,
    output logic [CntWidth-1:0] period_o,
    output logic                valid_o,
    output logic                mismatch_o,
    output logic                error_o,
    output logic                timeout_o,
    output logic [CntWidth-1:0] min_o,
    output logic [CntWidth-1:0] max_o
);

    localparam logic [CntWidth-1:0] CntMax = '1;

    logic                meas_sync;
    logic                prev_q, prev_d;
    logic                edge_det;
    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    status_t             status_q, status_d;
    logic                mis_set, to_set;
    logic [CntWidth:0]   diff;
    logic                check_fail;

    sync #(
        .STAGES     (SyncStages),
        .ResetValue (1'b0)
    ) i_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .serial_i (clk_meas_i),
        .serial_o (meas_sync)
    );

    assign edge_det = meas_sync & ~prev_q;

    // absolute deviation of the running count from the expected period;
    // one extra bit so the subtraction never wraps
    always_comb begin
        if ({1'b0, cnt_q} >= {1'b0, exp_period_i})
            diff = {1'b0, cnt_q} - {1'b0, exp_period_i};
        else
            diff = {1'b0, exp_period_i} - {1'b0, cnt_q};
        check_fail = (exp_period_i != '0) && (diff > {1'b0, tol_i});
    end

    // FSM next state, period counter and result capture
    always_comb begin
        prev_d   = meas_sync;
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        mis_set  = 1'b0;
        to_set   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i) state_d = ARM;
            end
            ARM: begin
                // first edge only starts the count, nothing to report yet
                cnt_d = '0;
                if (edge_det) begin
                    state_d = MEASURE;
                    cnt_d   = CntWidth'(1);
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    mis_set  = check_fail;
                    cnt_d    = CntWidth'(1);
                end else if (cnt_q == CntMax) begin
                    // no edge within the counter range: give up and re-arm
                    to_set  = 1'b1;
                    state_d = ARM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // disabling overrides everything; results already captured are kept
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            mis_set = 1'b0;
            to_set  = 1'b0;
        end
        // a set event in the same cycle as clear_i wins
        status_d.mismatch = mis_set;
        status_d.error    = (status_q.error   & ~clear_i) | mis_set;
        status_d.timeout  = (status_q.timeout & ~clear_i) | to_set;
    end

    // state, counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            status_q <= '0;
        end else begin
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            status_q <= status_d;
        end
    end

    assign period_o   = period_q;
    assign valid_o    = valid_q;
    assign mismatch_o = status_q.mismatch;
    assign error_o    = status_q.error;
    assign timeout_o  = status_q.timeout;

`ifdef CLK_PERIOD_MONITOR_MINMAX_EN
    logic [CntWidth-1:0] min_q, min_d, max_q, max_d;

    // track extremes of reported periods; clear restarts tracking but a
    // period reported in the same cycle is still recorded
    always_comb begin
        min_d = clear_i ? '1 : min_q;
        max_d = clear_i ? '0 : max_q;
        if (valid_d) begin
            if (period_d < min_d) min_d = period_d;
            if (period_d > max_d) max_d = period_d;
        end
    end

    // extreme-value registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    assign min_o = '1;
    assign max_o = '0;
`endif

endmodule

// File: doc/clk_period_monitor.md
CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 Parameter CntWidth, default 16: width of the period counter and of all period values.
REQ-002 Parameter SyncStages, default 2: number of synchronizer flops on clk_meas_i.
REQ-003 clk_i  in  1  reference clock; the one clock of the block.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 en_i  in  1  monitor enable; low = idle.
REQ-006 clear_i  in  1  clears sticky flags.
REQ-007 clk_meas_i  in  1  monitored clock (e.g. a divided-clock output), asynchronous, treated as data.
REQ-008 exp_period_i  in  CntWidth  expected period in clk_i cycles; 0 disables checking.
REQ-009 tol_i  in  CntWidth  allowed absolute deviation in cycles.
REQ-010 period_o  out  CntWidth  last measured period.
REQ-011 valid_o  out  1  one-cycle pulse when period_o is updated.
REQ-012 mismatch_o  out  1  one-cycle pulse with valid_o when the check fails.
REQ-013 error_o  out  1  sticky mismatch flag.
REQ-014 timeout_o  out  1  sticky timeout flag.
REQ-015 min_o, max_o  out  CntWidth each  extreme periods seen (see Configuration).

Function
REQ-016 clk_meas_i SHALL pass through SyncStages flops, then a rising edge SHALL be detected as sync_q & ~prev_q; detection latency is SyncStages+1 clk_i cycles.
REQ-017 FSM states: IDLE, ARM, MEASURE; IDLE->ARM when en_i=1; ARM->MEASURE on the first detected edge (no measurement); MEASURE->ARM on timeout; any state->IDLE when en_i=0.
REQ-018 In MEASURE, the counter SHALL load 1 on each edge and otherwise increment, saturating at 2^CntWidth-1.
REQ-019 On an edge in MEASURE: period_o <= counter value, valid_o = 1 for one cycle; two edges N cycles apart SHALL give period_o = N.
REQ-020 Check: diff = |period - exp_period_i| in CntWidth+1 bits; if exp_period_i != 0 and diff > tol_i, then mismatch_o = 1 with valid_o and error_o is set.
REQ-021 When the counter reaches 2^CntWidth-1 in MEASURE, timeout_o SHALL be set, valid_o SHALL stay 0, and the FSM SHALL go to ARM.
REQ-022 clear_i SHALL clear error_o and timeout_o; a set event in the same cycle wins.
REQ-023 en_i=0 SHALL zero the counter and suppress valid_o/mismatch_o; period_o, error_o, and timeout_o hold their values.
REQ-024 Supported input: every high and low phase of clk_meas_i is at least 1 clk_i cycle (period >= 2); shorter phases are undefined.

Reset
REQ-025 Asynchronous reset SHALL force IDLE, clear the counter and synchronizer flops, and set period_o=0, valid_o=0, mismatch_o=0, error_o=0, timeout_o=0, min_o=all ones, max_o=0.
REQ-026 A reset asserted mid-period SHALL discard the partial count; after release, the first edge only arms the FSM.

Configuration
REQ-027 Macro CLK_PERIOD_MONITOR_MINMAX_EN: when defined, min_o/max_o SHALL track the extreme valid periods and reset to their reset values on clear_i.
REQ-028 Without the macro, min_o SHALL be tied to all ones and max_o to 0, with no tracking logic.

Structure
REQ-029 The package clk_period_monitor_pkg SHALL hold the FSM state enum (IDLE/ARM/MEASURE) and a status struct (error, timeout, mismatch).
REQ-030 The synchronizer SHALL be the existing common_cells sub-module sync, instantiated with STAGES=SyncStages.

Verification
REQ-031 clk_meas_i from clk_int_div_static DIV_VALUE=4, exp=4, tol=0 -> valid_o every 4 cycles, period_o=4, error_o=0.
REQ-032 DIV_VALUE=5, exp=4, tol=0 -> first valid_o gives mismatch_o=1 and error_o=1; with tol=1 -> error_o stays 0.
REQ-033 CntWidth=8, clk_meas_i held low after arming -> timeout_o=1 at 255 counted cycles and no valid_o.
REQ-034 en_i low for 7 cycles mid-period, DIV_VALUE=6 -> no valid_o for the first edge after re-enable; the next valid_o gives period_o=6.
REQ-035 clear_i asserted in the same cycle as a mismatch -> error_o remains 1; clear_i alone -> error_o=0 next cycle.
REQ-036 With the macro defined, alternate DIV 3 and DIV 7 sources -> min_o=3, max_o=7; without the macro -> min_o=all ones, max_o=0.
